// File: rtl/fft_16pt.sv
// Iterative 16-point radix-2 DIT complex FFT, one butterfly stage per clock.
// Samples are captured bit-reversed at start; bins come out in natural order.
module fft_16pt #(
  parameter int WIDTH = 36
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] f [0:15],
  input  logic                    start,
  output logic signed [WIDTH-1:0] F [0:15],
  output logic                    done
);

  localparam int H  = WIDTH / 2;
  localparam int PW = H + 18;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                  state;
  logic [2:0]              stage;
  logic signed [WIDTH-1:0] work [0:15];
  logic signed [WIDTH-1:0] nxt  [0:15];

  // W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q2.14
  function automatic logic signed [15:0] twre(input logic [2:0] k);
    case (k)
      3'd0:    return 16'sd16384;
      3'd1:    return 16'sd15137;
      3'd2:    return 16'sd11585;
      3'd3:    return 16'sd6270;
      3'd4:    return 16'sd0;
      3'd5:    return -16'sd6270;
      3'd6:    return -16'sd11585;
      default: return -16'sd15137;
    endcase
  endfunction

  function automatic logic signed [15:0] twim(input logic [2:0] k);
    case (k)
      3'd0:    return 16'sd0;
      3'd1:    return -16'sd6270;
      3'd2:    return -16'sd11585;
      3'd3:    return -16'sd15137;
      3'd4:    return -16'sd16384;
      3'd5:    return -16'sd15137;
      3'd6:    return -16'sd11585;
      default: return -16'sd6270;
    endcase
  endfunction

  function automatic logic [3:0] bitrev(input logic [3:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction

  // Upper index of butterfly p at stage s: group (p >> s) spans 2^(s+1) entries
  function automatic logic [3:0] topidx(input logic [2:0] p, input logic [1:0] s);
    case (s)
      2'd0:    return {p, 1'b0};
      2'd1:    return {p[2:1], 1'b0, p[0]};
      2'd2:    return {p[2], 1'b0, p[1:0]};
      default: return {1'b0, p};
    endcase
  endfunction

  function automatic logic [3:0] botidx(input logic [2:0] p, input logic [1:0] s);
    return topidx(p, s) | (4'b0001 << s);
  endfunction

  function automatic logic [2:0] twidx(input logic [2:0] p, input logic [1:0] s);
    case (s)
      2'd0:    return 3'd0;
      2'd1:    return {p[0], 2'b00};
      2'd2:    return {p[1:0], 1'b0};
      default: return p;
    endcase
  endfunction

  // Rounded Q2.14 complex multiply; W^0 and W^4 come out exact
  function automatic logic signed [WIDTH-1:0] cmul(input logic signed [WIDTH-1:0] b,
                                                   input logic [2:0] k);
    logic signed [H-1:0]  br, bi, pr, pi;
    logic signed [15:0]   wr, wi;
    logic signed [PW-1:0] accr, acci;
    br   = b[WIDTH-1:H];
    bi   = b[H-1:0];
    wr   = twre(k);
    wi   = twim(k);
    accr = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi) + PW'(8192);
    acci = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr) + PW'(8192);
    accr = accr >>> 14;
    acci = acci >>> 14;
    pr   = accr[H-1:0];
    pi   = acci[H-1:0];
    return {pr, pi};
  endfunction

  function automatic logic [2*WIDTH-1:0] bfly(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b,
                                             input logic [2:0] k);
    logic signed [WIDTH-1:0] t;
    logic signed [H-1:0]     sr, si, dr, di;
    t  = cmul(b, k);
    sr = a[WIDTH-1:H] + t[WIDTH-1:H];
    si = a[H-1:0] + t[H-1:0];
    dr = a[WIDTH-1:H] - t[WIDTH-1:H];
    di = a[H-1:0] - t[H-1:0];
    return {sr, si, dr, di};
  endfunction

  always_comb begin
    nxt = work;
    for (int p = 0; p < 8; p++) begin
      {nxt[topidx(3'(p), stage[1:0])], nxt[botidx(3'(p), stage[1:0])]} =
        bfly(work[topidx(3'(p), stage[1:0])], work[botidx(3'(p), stage[1:0])],
             twidx(3'(p), stage[1:0]));
    end
  end

  // Stage counter runs 0..3 through the butterflies; stage 4 publishes to F
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      stage <= '0;
      done  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        work[i] <= '0;
        F[i]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 16; i++) work[i] <= f[bitrev(4'(i))];
            stage <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (stage == 3'd4) begin
            F     <= work;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            work  <= nxt;
            stage <= stage + 3'd1;
          end
        end
        FINISH: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_16pt.sv
// Directed bench for fft_16pt: a floating-point DFT model fills a scoreboard
// when each transform starts, and bins are checked when done rises.
module tb_fft_16pt;

  localparam int WIDTH = 36;
  localparam int H     = WIDTH / 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic signed [WIDTH-1:0] f [0:15];
  logic                    start;
  logic signed [WIDTH-1:0] F [0:15];
  logic                    done;

  int nAsserts = 0;
  int nFail    = 0;
  int expRe[$];
  int expIm[$];
  int expTol[$];
  int xr[16];
  int xi[16];

  always #5 clock = ~clock;

  fft_16pt #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .f(f),
    .start(start),
    .F(F),
    .done(done)
  );

  function automatic int reOf(input logic signed [WIDTH-1:0] w);
    logic signed [H-1:0] r;
    r = w[WIDTH-1:H];
    return int'(r);
  endfunction

  function automatic int imOf(input logic signed [WIDTH-1:0] w);
    logic signed [H-1:0] r;
    r = w[H-1:0];
    return int'(r);
  endfunction

  task automatic checkVal(input string tag, input int observed, input int expected, input int tol);
    int d;
    d = observed - expected;
    if (d < 0) d = -d;
    nAsserts++;
    assert (d <= tol) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Reference DFT of xr/xi, rounded to nearest, pushed to the scoreboard
  task automatic pushModel(input int tol);
    real sr, si, ang;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = 2.0 * 3.14159265358979323846 * real'(n * k) / 16.0;
        sr  = sr + real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
        si  = si + real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
      end
      expRe.push_back(int'(sr));
      expIm.push_back(int'(si));
    end
    expTol.push_back(tol);
  endtask

  task automatic applyStimulus(input int tol);
    @(negedge clock);
    for (int i = 0; i < 16; i++) f[i] = {H'(xr[i]), H'(xi[i])};
    pushModel(tol);
    start = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input bit hold);
    int cycles;
    int tol;
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (cycles == 1 && !hold) start = 1'b0;
      if (cycles == 2) for (int i = 0; i < 16; i++) f[i] = {H'(i * 37 + 5), H'(-i * 11 - 3)};
    end
    checkVal({tag, "_latency"}, cycles - 1, 5, 0);
    if (expRe.size() < 16 || expTol.size() < 1) begin
      nAsserts++;
      nFail++;
      $error("[TB] FAIL %s_scoreboard observed=%0d entries expected=16", tag, expRe.size());
    end else begin
      tol = expTol.pop_front();
      for (int k = 0; k < 16; k++) begin
        checkVal($sformatf("%s_re%0d", tag, k), reOf(F[k]), expRe.pop_front(), tol);
        checkVal($sformatf("%s_im%0d", tag, k), imOf(F[k]), expIm.pop_front(), tol);
      end
    end
  endtask

  task automatic idleCycles();
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) f[i] = '0;
    repeat (3) @(negedge clock);
    checkBit("reset_done", done, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checkVal($sformatf("reset_F%0d", k), reOf(F[k]) | imOf(F[k]), 0, 0);
    end
    reset = 1'b0;
    idleCycles();

    $display("[TB] impulse at x[0]");
    for (int i = 0; i < 16; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[0] = 1000;
    applyStimulus(0);
    checkOutput("impulse", 1'b0);
    idleCycles();

    $display("[TB] DC input");
    for (int i = 0; i < 16; i++) begin xr[i] = 100; xi[i] = 0; end
    applyStimulus(1);
    checkOutput("dc", 1'b0);
    idleCycles();

    $display("[TB] period-4 input");
    for (int i = 0; i < 16; i++) begin xr[i] = 100 + 50 * (i % 4); xi[i] = 0; end
    applyStimulus(1);
    checkOutput("per4", 1'b0);
    idleCycles();

    $display("[TB] impulse at x[1]");
    for (int i = 0; i < 16; i++) begin xr[i] = 0; xi[i] = 0; end
    xr[1] = 1000;
    applyStimulus(2);
    checkOutput("delayed", 1'b0);
    checkVal("delayed_exact_re4", reOf(F[4]), 0, 0);
    checkVal("delayed_exact_im4", imOf(F[4]), -1000, 0);
    checkVal("delayed_exact_re8", reOf(F[8]), -1000, 0);
    checkVal("delayed_exact_im8", imOf(F[8]), 0, 0);
    idleCycles();

    $display("[TB] handshake with start held high");
    for (int i = 0; i < 16; i++) begin xr[i] = 100; xi[i] = 0; end
    applyStimulus(1);
    checkOutput("hold", 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checkBit($sformatf("hold_done_c%0d", c), done, 1'b1);
    end
    checkVal("hold_F0_stable", reOf(F[0]), 1600, 0);
    start = 1'b0;
    @(negedge clock);
    checkBit("drop_done", done, 1'b0);
    checkVal("idle_F0_kept", reOf(F[0]), 1600, 0);
    for (int i = 0; i < 16; i++) begin xr[i] = 20 * i - 150; xi[i] = 7 * i; end
    applyStimulus(4);
    checkOutput("restart", 1'b0);
    idleCycles();

    $display("[TB] reset during RUN");
    for (int i = 0; i < 16; i++) f[i] = {H'(300), H'(-200)};
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkBit("abort_done", done, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checkVal($sformatf("abort_F%0d", k), reOf(F[k]) | imOf(F[k]), 0, 0);
    end
    @(negedge clock);
    reset = 1'b0;
    idleCycles();
    checkBit("abort_no_done", done, 1'b0);

    $display("[TB] random transform after reset");
    for (int i = 0; i < 16; i++) begin
      xr[i] = int'($urandom_range(400)) - 200;
      xi[i] = int'($urandom_range(400)) - 200;
    end
    applyStimulus(4);
    checkOutput("random", 1'b0);
    idleCycles();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
